// File: rtl/dac_serial_tx_pkg.sv
// rtl/dac_serial_tx_pkg.sv - shared frame constants and FSM encoding for the serial DAC transmitter
package dac_serial_tx_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DAC_BITS   = 12;
  localparam logic [FRAME_BITS-DAC_BITS-1:0] PD_BITS = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_END   = 2'd3
  } state_t;

endpackage

// File: rtl/dac_serial_tx_if.sv
// rtl/dac_serial_tx_if.sv - sample-side handshake plus serial DAC pins
interface dac_serial_tx_if #(
  parameter int Width = 18
);

  logic                    start;
  logic signed [Width-1:0] yk;
  logic                    busy;
  logic                    done;
  logic                    ovr;
  logic                    dac_sclk;
  logic                    dac_sync_n;
  logic                    dac_din;

  modport master (
    output start, yk,
    input  busy, done, ovr, dac_sclk, dac_sync_n, dac_din
  );

  modport slave (
    input  start, yk,
    output busy, done, ovr, dac_sclk, dac_sync_n, dac_din
  );

endinterface

// File: rtl/dac_serial_tx_q_to_dac_code.sv
// rtl/dac_serial_tx_q_to_dac_code.sv - saturate a signed Q p.f sample to an offset-binary DAC code
module q_to_dac_code #(
  parameter int p        = 4,
  parameter int f        = 13,
  parameter int DAC_BITS = 12
) (
  input  logic signed [p+f:0]    yk,
  output logic [DAC_BITS-1:0]    code
);

  localparam int W  = 1 + p + f;
  localparam int SH = f + 1 - DAC_BITS;
  localparam logic signed [W:0] FULL = $signed({{(W-f){1'b0}}, 1'b1, {f{1'b0}}});

  logic signed [W:0] yk_ext;

  // Inside (-2^f, 2^f) the +2^f offset is just an inversion of bit f.
  always_comb begin
    yk_ext = {yk[W-1], yk};
    if (yk_ext >= FULL) begin
      code = '1;
    end else if (yk_ext < -FULL) begin
      code = '0;
    end else begin
      code = {~yk[f], yk[f-1:SH]};
    end
  end

endmodule

// File: rtl/dac_serial_tx.sv
// rtl/dac_serial_tx.sv - converts each filter sample to a DAC code and shifts it out as a 16-bit frame
module dac_serial_tx #(
  parameter int p   = 4,
  parameter int f   = 13,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  dac_serial_tx_if.slave bus
);

  import dac_serial_tx_pkg::*;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_PEN  = DW'((DIV > 1) ? DIV - 2 : 0);

  state_t                state;
  logic [DW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [DAC_BITS-1:0]   code;
  logic [FRAME_BITS-1:0] frame;

  q_to_dac_code #(.p(p), .f(f), .DAC_BITS(DAC_BITS)) u_conv (
    .yk   (bus.yk),
    .code (code)
  );

  assign frame = {PD_BITS, code};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ovr        <= 1'b0;
      bus.dac_sclk   <= 1'b1;
      bus.dac_sync_n <= 1'b1;
      bus.dac_din    <= 1'b0;
    end else begin
      if (bus.start && state != ST_IDLE) begin
        bus.ovr <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shreg          <= frame;
            bit_cnt        <= 4'd15;
            div_cnt        <= '0;
            bus.busy       <= 1'b1;
            bus.dac_sync_n <= 1'b0;
            bus.dac_sclk   <= 1'b1;
            bus.dac_din    <= frame[FRAME_BITS-1];
            state          <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bus.dac_sclk <= 1'b0;
          div_cnt      <= '0;
          state        <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!bus.dac_sclk) begin
              // Rising edge: present the next bit while the DAC is not sampling.
              bus.dac_sclk <= 1'b1;
              if (bit_cnt != 4'd0) begin
                bus.dac_din <= shreg[bit_cnt - 4'd1];
              end
            end else if (bit_cnt == 4'd0) begin
              bus.dac_sync_n <= 1'b1;
              bus.dac_din    <= 1'b0;
              bus.done       <= (DIV == 1);
              state          <= ST_END;
            end else begin
              bus.dac_sclk <= 1'b0;
              bit_cnt      <= bit_cnt - 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        ST_END: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + DW'(1);
            if (div_cnt == DIV_PEN) begin
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// tb/tb_dac_serial_tx.sv - scoreboard bench for dac_serial_tx, DIV=4 and DIV=1 instances
module tb_dac_serial_tx;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [15:0] sb[$];

  dac_serial_tx_if #(.Width(18)) b0 ();
  dac_serial_tx_if #(.Width(18)) b1 ();

  dac_serial_tx #(.p(4), .f(13), .DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dac_serial_tx #(.p(4), .f(13), .DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy, done, ovr, sclk, sync_n, din}
  function automatic logic [5:0] outs(input int i);
    if (i == 0) return {b0.busy, b0.done, b0.ovr, b0.dac_sclk, b0.dac_sync_n, b0.dac_din};
    return {b1.busy, b1.done, b1.ovr, b1.dac_sclk, b1.dac_sync_n, b1.dac_din};
  endfunction

  function automatic logic [15:0] model(input logic signed [17:0] y);
    int v;
    int c;
    v = int'(y);
    if (v >= 8192) c = 4095;
    else if (v < -8192) c = 0;
    else c = (v + 8192) / 4;
    return 16'(c);
  endfunction

  task automatic send(input int inst, input logic signed [17:0] y);
    @(negedge clk);
    if (inst == 0) begin b0.start = 1'b1; b0.yk = y; end
    else begin b1.start = 1'b1; b1.yk = y; end
    sb.push_back(model(y));
    @(posedge clk);
    #1;
    b0.start = 1'b0;
    b1.start = 1'b0;
  endtask

  task automatic collect(input int inst, input string tag, input int exp_cyc, input int pulse_at);
    int cyc, falls, sync_bad;
    logic prev, got;
    logic [5:0] o;
    logic [15:0] shv, exp;
    cyc = 0; falls = 0; sync_bad = 0; prev = 1'b1; got = 1'b0; shv = '0; o = '0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (pulse_at != 0) begin
        if (cyc == pulse_at) begin b0.start = 1'b1; b0.yk = 18'h1FFFF; end
        else b0.start = 1'b0;
      end
      o = outs(inst);
      if (cyc == 1) check({tag, "_load"}, {26'd0, o}, {26'd0, 6'b100100 | {2'b00, o[3], 3'b000}});
      if (!o[2] && o[1]) sync_bad++;
      if (prev && !o[2] && !o[1]) begin
        shv = {shv[14:0], o[0]};
        falls++;
      end
      prev = o[2];
      if (o[4]) got = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({tag, "_cycles"}, cyc, exp_cyc);
      check({tag, "_busy_at_done"}, {31'd0, o[5]}, 32'd1);
      check({tag, "_sync_in_shift"}, sync_bad, 0);
      check({tag, "_falls"}, falls, 16);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check({tag, "_frame"}, {16'd0, shv}, {16'd0, exp});
      end else begin
        check({tag, "_sb_empty"}, sb.size(), 1);
      end
      @(negedge clk);
      o = outs(inst);
      check({tag, "_idle_after"}, {29'd0, o[5], o[4], o[1]}, 32'b001);
    end
  endtask

  initial begin
    logic signed [17:0] vec[8];
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    b0.start = 1'b0; b0.yk = '0;
    b1.start = 1'b0; b1.yk = '0;
    vec[0] = 18'h00000; vec[1] = 18'h01000; vec[2] = 18'h3E000; vec[3] = 18'h02000;
    vec[4] = 18'h1FFFF; vec[5] = 18'h20000;
    vec[6] = 18'($urandom_range(0, 18'h3FFFF));
    vec[7] = 18'($urandom_range(18'h3E001, 18'h3FFFF));

    repeat (3) @(negedge clk);
    check("reset_outs0", {26'd0, outs(0)}, 32'b000110);
    check("reset_outs1", {26'd0, outs(1)}, 32'b000110);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(0, vec[i]);
      collect(0, $sformatf("frame%0d", i), 133, 0);
    end
    check("ovr_clear", {31'd0, b0.ovr}, 32'd0);

    send(0, 18'h01000);
    collect(0, "overrun", 133, 50);
    check("ovr_set", {31'd0, b0.ovr}, 32'd1);
    send(0, 18'h00000);
    collect(0, "after_ovr", 133, 0);
    check("ovr_sticky", {31'd0, b0.ovr}, 32'd1);

    send(0, 18'h01000);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst", {26'd0, outs(0)}, 32'b000110);
    rst = 1'b0;
    sb.delete();
    send(0, 18'h3F000);
    collect(0, "post_rst", 133, 0);

    send(1, 18'h00800);
    collect(1, "div1_a", 34, 0);
    send(1, 18'h3C123);
    collect(1, "div1_b", 34, 0);
    send(1, 18'h1ABCD);
    collect(1, "div1_c", 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
